clock_display_scanner: RTL
==========================

// Module: clock_display_scanner
// PURPOSE
//  Reads the clock's binary HOUR/MIN/SEC counts and drives a 6-digit, time-multiplexed
//  7-segment display (HH:MM:SS). It is the consumer of the counter chain: it snapshots
//  the count on a load strobe and shows the snapshot in BCD, one digit at a time.
//  Display updates only at frame boundaries, so a frame never shows a partial update.
// PARAMETERS
//  BITS      6     width of MIN/SEC inputs (HOUR is 5 bits)
//  SCAN_DIV  1000  clock cycles each digit stays lit; legal range 1..65535
//  DIV_W     16    prescaler width; must satisfy 2**DIV_W >= SCAN_DIV
// PORTS
//  clock       in   1     system clock, rising edge
//  reset       in   1     asynchronous, active-low reset
//  enable      in   1     scan enable; low = display dark, scan frozen
//  load        in   1     one-cycle strobe: capture HOUR/MIN/SEC into pending snapshot
//  blank_lz    in   1     1 = blank hour-tens digit when it is 0
//  HOUR        in   5     binary hours, valid 0..23
//  MIN         in   BITS  binary minutes, valid 0..59
//  SEC         in   BITS  binary seconds, valid 0..59
//  SEG         out  7     segments {g,f,e,d,c,b,a}, active-high
//  DIG         out  6     one-hot digit enable, active-high; [0]=sec units .. [5]=hour tens
//  frame_done  out  1     one-cycle pulse when digit index wraps from 5 to 0
// BEHAVIOUR
//  - Reset (reset==0, async): pending and shown snapshots = 00:00:00, prescaler=0,
//    digit index=0, SEG=0, DIG=0, frame_done=0.
//  - load: pending <= {HOUR,MIN,SEC} on the same edge. Multiple loads in one frame:
//    the last one wins.
//  - Frame boundary: prescaler terminal (count==SCAN_DIV-1) and index==5. On that edge,
//    shown <= pending, index <= 0, frame_done=1 for one cycle.
//  - load on the boundary edge: the new inputs go straight to shown, bypassing pending.
//  - Prescaler counts only while enable=1. At terminal: prescaler <= 0 and
//    index <= (index==5) ? 0 : index+1. SCAN_DIV=1 advances the index every cycle.
//  - enable=0: prescaler and index hold; SEG=0 and DIG=0 from the next edge.
//    load is still accepted.
//  - Outputs are registered, one cycle after the index/snapshot: DIG=1<<index and
//    SEG=decode(digit[index]).
//  - BCD split per field: tens = v/10, units = v%10, done with a compare/subtract chain
//    (no divider).
//  - Field out of range (HOUR>23, MIN or SEC>59): both digits of that field show a dash
//    (SEG=7'h40). Leading-zero blanking does not apply to dashes.
//  - Blank: blank_lz=1, index==5, hour tens==0, field valid -> SEG=0, DIG still asserted.
//  - Segment codes 0..9: 3F 06 5B 4F 66 6D 7D 07 7F 6F.
// STRUCTURE
//  - Shared include clock_pkg.vh: SEG_0..SEG_9 and SEG_DASH codes, NUM_DIGITS=6,
//    MAX_HOUR=23, MAX_MINSEC=59.
//  - Sub-module seg7_decode: 4-bit BCD in, 7-bit segments out, combinational,
//    4'hF maps to dash.
//  - Top level holds the prescaler, digit index, pending/shown snapshots, BCD split
//    and output registers.
// TESTING
//  1. Reset then enable=1, SCAN_DIV=4 -> DIG walks 01,02,04,08,10,20, 4 cycles each;
//     SEG=3F on every digit; frame_done pulses every 24 cycles.
//  2. load with 13:45:07 mid-frame -> display keeps old digits until the next frame;
//     then digits 5..0 show 06,4F,66,6D,3F,07.
//  3. load on the exact frame-boundary edge with 09:00:59 -> the following frame shows it;
//     blank_lz=1 -> hour-tens SEG=00 with DIG=20.
//  4. MIN=60 with load -> minute digits SEG=40; hour and second digits unaffected;
//     HOUR=0 with blank_lz=1 still blanks hour tens.
//  5. enable dropped for 10 cycles mid-digit -> SEG=DIG=0; on re-enable, scan resumes
//     at the same index and prescaler count.
//  6. reset asserted mid-frame, asynchronously -> all outputs 0 immediately;
//     after release, shows 00:00:00 starting at DIG=01.

Source files
------------

// File: rtl/clock_display_scanner_pkg.sv
// rtl/clock_display_scanner_pkg.sv - shared constants and BCD helper for the HH:MM:SS display scanner
// Contents: segment codes {g,f,e,d,c,b,a}, digit count, field limits,
//           bcd_split() compare/subtract binary-to-BCD for values 0..69.
package clock_display_scanner_pkg;

  localparam logic [6:0] SEG_0    = 7'h3F;
  localparam logic [6:0] SEG_1    = 7'h06;
  localparam logic [6:0] SEG_2    = 7'h5B;
  localparam logic [6:0] SEG_3    = 7'h4F;
  localparam logic [6:0] SEG_4    = 7'h66;
  localparam logic [6:0] SEG_5    = 7'h6D;
  localparam logic [6:0] SEG_6    = 7'h7D;
  localparam logic [6:0] SEG_7    = 7'h07;
  localparam logic [6:0] SEG_8    = 7'h7F;
  localparam logic [6:0] SEG_9    = 7'h6F;
  localparam logic [6:0] SEG_DASH = 7'h40;
  localparam logic [6:0] SEG_OFF  = 7'h00;

  // Digit code the decoder renders as a dash.
  localparam logic [3:0] BCD_DASH = 4'hF;

  localparam int NUM_DIGITS = 6;
  localparam int MAX_HOUR   = 23;
  localparam int MAX_MINSEC = 59;

  // Returns {tens, units}. Subtracting 40, 20, 10 in turn covers every
  // in-range field value without a divider.
  function automatic logic [7:0] bcd_split(input logic [6:0] v);
    logic [6:0] r;
    logic [3:0] t;
    r = v;
    t = 4'd0;
    if (r >= 7'd40) begin
      r = r - 7'd40;
      t = t + 4'd4;
    end
    if (r >= 7'd20) begin
      r = r - 7'd20;
      t = t + 4'd2;
    end
    if (r >= 7'd10) begin
      r = r - 7'd10;
      t = t + 4'd1;
    end
    return {t, 4'(r)};
  endfunction

endpackage

// File: rtl/seg7_decode.sv
// rtl/seg7_decode.sv - combinational BCD digit to 7-segment decoder
// Ports: bcd in [3:0] digit (0..9, 4'hF = dash); seg out [6:0] {g,f,e,d,c,b,a}, active-high.
module seg7_decode
  import clock_display_scanner_pkg::*;
(
  input  logic [3:0] bcd,
  output logic [6:0] seg
);

  always_comb begin
    seg = SEG_OFF;
    case (bcd)
      4'd0:     seg = SEG_0;
      4'd1:     seg = SEG_1;
      4'd2:     seg = SEG_2;
      4'd3:     seg = SEG_3;
      4'd4:     seg = SEG_4;
      4'd5:     seg = SEG_5;
      4'd6:     seg = SEG_6;
      4'd7:     seg = SEG_7;
      4'd8:     seg = SEG_8;
      4'd9:     seg = SEG_9;
      BCD_DASH: seg = SEG_DASH;
      default:  seg = SEG_OFF;
    endcase
  end

endmodule

// File: rtl/clock_display_scanner.sv
// rtl/clock_display_scanner.sv - snapshots HOUR/MIN/SEC and scans them onto a 6-digit 7-segment display
// Ports: clock, reset (async active-low), enable (scan enable), load (snapshot strobe),
//        blank_lz (blank zero hour tens), HOUR[4:0], MIN/SEC[BITS-1:0] binary inputs,
//        SEG[6:0] segments, DIG[5:0] one-hot digit ([0]=sec units), frame_done pulse.
module clock_display_scanner
  import clock_display_scanner_pkg::*;
#(
  parameter int BITS     = 6,
  parameter int SCAN_DIV = 1000,
  parameter int DIV_W    = 16
) (
  input  logic            clock,
  input  logic            reset,
  input  logic            enable,
  input  logic            load,
  input  logic            blank_lz,
  input  logic [4:0]      HOUR,
  input  logic [BITS-1:0] MIN,
  input  logic [BITS-1:0] SEC,
  output logic [6:0]      SEG,
  output logic [5:0]      DIG,
  output logic            frame_done
);

  localparam logic [DIV_W-1:0] PRESC_LAST = DIV_W'(SCAN_DIV - 1);
  localparam logic [2:0]       IDX_LAST   = 3'(NUM_DIGITS - 1);
  localparam logic [4:0]       HOUR_MAX   = 5'(MAX_HOUR);
  localparam logic [BITS-1:0]  MINSEC_MAX = BITS'(MAX_MINSEC);

  logic [DIV_W-1:0] presc_q, presc_d;
  logic [2:0]       idx_q, idx_d;
  logic [4:0]       pend_hour_q, pend_hour_d;
  logic [BITS-1:0]  pend_min_q, pend_min_d;
  logic [BITS-1:0]  pend_sec_q, pend_sec_d;
  logic [4:0]       shown_hour_q, shown_hour_d;
  logic [BITS-1:0]  shown_min_q, shown_min_d;
  logic [BITS-1:0]  shown_sec_q, shown_sec_d;
  logic [6:0]       seg_q, seg_d;
  logic [5:0]       dig_q, dig_d;
  logic             frame_done_q, frame_done_d;

  logic       terminal;
  logic       boundary;
  logic       hour_ok, min_ok, sec_ok;
  logic [7:0] hour_bcd, min_bcd, sec_bcd;
  logic [3:0] digit;
  logic       blank;
  logic [6:0] dec_seg;

  seg7_decode u_dec (
    .bcd (digit),
    .seg (dec_seg)
  );

  always_comb begin
    terminal = enable && (presc_q == PRESC_LAST);
    boundary = terminal && (idx_q == IDX_LAST);

    // Prescaler and digit index freeze while disabled.
    presc_d = presc_q;
    idx_d   = idx_q;
    if (enable) begin
      if (terminal) begin
        presc_d = '0;
        idx_d   = (idx_q == IDX_LAST) ? 3'd0 : idx_q + 3'd1;
      end else begin
        presc_d = presc_q + 1'b1;
      end
    end

    pend_hour_d = load ? HOUR : pend_hour_q;
    pend_min_d  = load ? MIN  : pend_min_q;
    pend_sec_d  = load ? SEC  : pend_sec_q;

    // pend_*_d already carries a same-edge load, so a load on the boundary
    // edge reaches the shown snapshot directly.
    shown_hour_d = boundary ? pend_hour_d : shown_hour_q;
    shown_min_d  = boundary ? pend_min_d  : shown_min_q;
    shown_sec_d  = boundary ? pend_sec_d  : shown_sec_q;

    hour_ok  = shown_hour_q <= HOUR_MAX;
    min_ok   = shown_min_q  <= MINSEC_MAX;
    sec_ok   = shown_sec_q  <= MINSEC_MAX;
    hour_bcd = bcd_split(7'(shown_hour_q));
    min_bcd  = bcd_split(7'(shown_min_q));
    sec_bcd  = bcd_split(7'(shown_sec_q));

    digit = BCD_DASH;
    case (idx_q)
      3'd0:    digit = sec_ok  ? sec_bcd[3:0]  : BCD_DASH;
      3'd1:    digit = sec_ok  ? sec_bcd[7:4]  : BCD_DASH;
      3'd2:    digit = min_ok  ? min_bcd[3:0]  : BCD_DASH;
      3'd3:    digit = min_ok  ? min_bcd[7:4]  : BCD_DASH;
      3'd4:    digit = hour_ok ? hour_bcd[3:0] : BCD_DASH;
      3'd5:    digit = hour_ok ? hour_bcd[7:4] : BCD_DASH;
      default: digit = BCD_DASH;
    endcase

    // Only a real zero is blanked; an out-of-range hour keeps its dash.
    blank = blank_lz && (idx_q == IDX_LAST) && hour_ok && (hour_bcd[7:4] == 4'd0);

    seg_d        = (enable && !blank) ? dec_seg : SEG_OFF;
    dig_d        = enable ? (6'b1 << idx_q) : 6'b0;
    frame_done_d = boundary;
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      presc_q      <= '0;
      idx_q        <= 3'd0;
      pend_hour_q  <= '0;
      pend_min_q   <= '0;
      pend_sec_q   <= '0;
      shown_hour_q <= '0;
      shown_min_q  <= '0;
      shown_sec_q  <= '0;
      seg_q        <= SEG_OFF;
      dig_q        <= 6'b0;
      frame_done_q <= 1'b0;
    end else begin
      presc_q      <= presc_d;
      idx_q        <= idx_d;
      pend_hour_q  <= pend_hour_d;
      pend_min_q   <= pend_min_d;
      pend_sec_q   <= pend_sec_d;
      shown_hour_q <= shown_hour_d;
      shown_min_q  <= shown_min_d;
      shown_sec_q  <= shown_sec_d;
      seg_q        <= seg_d;
      dig_q        <= dig_d;
      frame_done_q <= frame_done_d;
    end
  end

  assign SEG        = seg_q;
  assign DIG        = dig_q;
  assign frame_done = frame_done_q;

endmodule
